morse_key_decoder: RTL

- Front end of the Morse receive path, directly upstream of the Morse-to-character stage.
- Synchronises and (optionally) debounces the raw key, times press and release durations in Morse units, and classifies each press as dot or dash.
- Emits a letter-gap symbol when the key has been idle long enough.
- Symbols are driven as sym_data with a registered sym_strobe pulse. The downstream stage samples sym_data on the rising edge of sym_strobe.

---
 rtl/morse_key_decoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/morse_key_decoder.sv
// Morse key front end: synchronises the key, times presses and idle gaps in units, and
// emits dot/dash/letter-gap symbols with a strobe. Define MORSE_DEBOUNCE_EN to debounce the key.
module morse_key_decoder #(
  parameter int UNIT_TICKS      = 1000000,
  parameter int DASH_UNITS      = 2,
  parameter int GAP_UNITS       = 3,
  parameter int MAX_SYMBOLS     = 4,
  parameter int STROBE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [1:0] sym_data,
  output logic       sym_strobe,
  output logic       key_level,
  output logic       overflow,
  output logic       busy
);

  localparam int PW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST    = PW'(UNIT_TICKS - 1);
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);
  localparam logic [7:0]    DASH_DUR    = 8'(DASH_UNITS);
  localparam logic [7:0]    GAP_DUR     = 8'(GAP_UNITS);
  localparam logic [3:0]    MAX_SYM     = 4'(MAX_SYMBOLS);

  typedef enum logic [1:0] {IDLE, PRESS, SPACE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic            level_next;
  logic [PW-1:0]   pre_reg;
  logic [7:0]      dur_reg, dur_now;
  logic [2:0]      sym_cnt_reg;
  logic [SW-1:0]   strobe_cnt_reg;
  logic            emit_d_reg;
  logic            rise, fall, key_edge, tick, gap_tick;
  logic            emit, drop, cnt_inc, clear_letter;
  logic [1:0]      emit_sym;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], key_in};
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [DW-1:0] db_cnt_reg;

  assign level_next = (sync_reg[1] != key_level && db_cnt_reg == DB_LAST) ? sync_reg[1] : key_level;

  // Any cycle where the synchronised key agrees with key_level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           db_cnt_reg <= '0;
    else if (sync_reg[1] == key_level || db_cnt_reg == DB_LAST) db_cnt_reg <= '0;
    else                                               db_cnt_reg <= db_cnt_reg + 1'b1;
  end
`else
  assign level_next = sync_reg[1];
`endif

  // key_level doubles as the edge detector's history, so timing is aligned to its transitions.
  assign rise     = level_next & ~key_level;
  assign fall     = ~level_next & key_level;
  assign key_edge = rise | fall;
  assign tick     = (pre_reg == PRE_LAST);
  assign dur_now  = (tick && dur_reg != 8'hFF) ? dur_reg + 8'd1 : dur_reg;
  assign gap_tick = tick && (dur_reg != GAP_DUR) && (dur_now == GAP_DUR);
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_level <= 1'b0;
      pre_reg   <= '0;
      dur_reg   <= 8'd0;
    end else begin
      key_level <= level_next;
      pre_reg   <= (key_edge || tick) ? '0 : pre_reg + 1'b1;
      dur_reg   <= key_edge ? 8'd0 : dur_now;
    end
  end

  always_comb begin
    state_next   = state_reg;
    emit         = 1'b0;
    emit_sym     = 2'b00;
    drop         = 1'b0;
    cnt_inc      = 1'b0;
    clear_letter = 1'b0;
    case (state_reg)
      IDLE: if (rise) state_next = PRESS;
      PRESS: begin
        if (fall) begin
          if ({1'b0, sym_cnt_reg} < MAX_SYM) begin
            emit     = 1'b1;
            emit_sym = (dur_now < DASH_DUR) ? 2'b01 : 2'b10;
          end else begin
            drop = 1'b1;
          end
          cnt_inc    = 1'b1;
          state_next = SPACE;
        end
      end
      SPACE: begin
        if (rise) begin
          state_next = PRESS;
        end else if (gap_tick) begin
          emit         = 1'b1;
          emit_sym     = 2'b00;
          clear_letter = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sym_data    <= 2'b00;
      overflow    <= 1'b0;
      sym_cnt_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (emit) sym_data <= emit_sym;
      if (clear_letter)                           sym_cnt_reg <= 3'd0;
      else if (cnt_inc && sym_cnt_reg != 3'd7)    sym_cnt_reg <= sym_cnt_reg + 3'd1;
      if (clear_letter) overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
    end
  end

  // Strobe starts the cycle after sym_data changes so the data is settled at its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emit_d_reg     <= 1'b0;
      sym_strobe     <= 1'b0;
      strobe_cnt_reg <= '0;
    end else begin
      emit_d_reg <= emit;
      if (emit_d_reg) begin
        sym_strobe     <= 1'b1;
        strobe_cnt_reg <= STROBE_LAST;
      end else if (strobe_cnt_reg != '0) begin
        strobe_cnt_reg <= strobe_cnt_reg - 1'b1;
      end else begin
        sym_strobe <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(emit && sym_strobe));
  assert property (@(posedge clk) (UNIT_TICKS >= STROBE_CYCLES + 2) && (DEBOUNCE_CYCLES >= 1));

endmodule
